// File: rtl/branch_cond_pkg.sv
// Shared definitions for the branch-condition unit: MIPS compare op codes and default widths.
package branch_cond_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LEZ  = 3'd3,
        BR_GTZ  = 3'd4,
        BR_LTZ  = 3'd5,
        BR_GEZ  = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: (op, a, b) -> cond, illegal.
module branch_cond_eval
    import branch_cond_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cond,
    output logic             illegal
);

    logic a_zero;
    logic a_neg;

    // Sign tests only need the MSB and a zero detect, no subtractor.
    assign a_zero = ~|a;
    assign a_neg  = a[WIDTH-1];

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (br_op_e'(op))
            BR_NONE: cond = 1'b0;
            BR_EQ:   cond = (a == b);
            BR_NE:   cond = (a != b);
            BR_LEZ:  cond = a_neg | a_zero;
            BR_GTZ:  cond = ~a_neg & ~a_zero;
            BR_LTZ:  cond = a_neg;
            BR_GEZ:  cond = ~a_neg;
            BR_RSVD: illegal = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch-condition stage for the ID/EX boundary with stall/flush
// handling and saturating resolved/taken branch counters.
module branch_cond_unit
    import branch_cond_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             taken,
    output logic             illegal,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic cond;
    logic op_illegal;
    logic capture;
    logic count_ev;

    logic             out_valid_d, out_valid_q;
    logic             taken_d,     taken_q;
    logic             illegal_d,   illegal_q;
    logic [CNT_W-1:0] cnt_branch_d, cnt_branch_q;
    logic [CNT_W-1:0] cnt_taken_d,  cnt_taken_q;

    branch_cond_eval #(.WIDTH(WIDTH)) u_eval (
        .op      (op),
        .a       (a),
        .b       (b),
        .cond    (cond),
        .illegal (op_illegal)
    );

    assign capture  = ~flush & ~stall;
    // NONE and reserved ops flow through the stage but are not real branches.
    assign count_ev = capture & in_valid & (op != BR_NONE) & ~op_illegal;

    always_comb begin
        out_valid_d = out_valid_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
            taken_d     = 1'b0;
            illegal_d   = 1'b0;
        end else if (!stall) begin
            out_valid_d = in_valid;
            taken_d     = in_valid & cond;
            illegal_d   = in_valid & op_illegal;
        end
    end

    always_comb begin
        cnt_branch_d = cnt_branch_q;
        cnt_taken_d  = cnt_taken_q;
        if (cnt_clr) begin
            cnt_branch_d = '0;
            cnt_taken_d  = '0;
        end else if (count_ev) begin
            cnt_branch_d = sat_inc(cnt_branch_q);
            if (cond) begin
                cnt_taken_d = sat_inc(cnt_taken_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            illegal_q    <= illegal_d;
            cnt_branch_q <= cnt_branch_d;
            cnt_taken_q  <= cnt_taken_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign taken      = taken_q;
    assign illegal    = illegal_q;
    assign cnt_branch = cnt_branch_q;
    assign cnt_taken  = cnt_taken_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: a 16-bit-counter and a 2-bit-counter instance share stimulus.
module tb_branch_cond_unit;
    import branch_cond_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        out_valid, taken, illegal;
    logic [15:0] cnt_branch, cnt_taken;
    logic        out_valid2, taken2, illegal2;
    logic [1:0]  cnt_branch2, cnt_taken2;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic m_vld = 1'b0, m_tkn = 1'b0, m_ill = 1'b0;
    int   m_cb = 0, m_ct = 0, m_cb2 = 0, m_ct2 = 0;

    branch_cond_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .taken(taken), .illegal(illegal),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
    );

    branch_cond_unit #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid2), .taken(taken2), .illegal(illegal2),
        .cnt_branch(cnt_branch2), .cnt_taken(cnt_taken2)
    );

    always #5 clk = ~clk;

    function automatic bit cond_ref(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd1: return x == y;
            3'd2: return x != y;
            3'd3: return $signed(x) <= 0;
            3'd4: return $signed(x) > 0;
            3'd5: return $signed(x) < 0;
            3'd6: return $signed(x) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit ev;
        if (reset) begin
            m_vld <= 1'b0; m_tkn <= 1'b0; m_ill <= 1'b0;
            m_cb <= 0; m_ct <= 0; m_cb2 <= 0; m_ct2 <= 0;
        end else begin
            if (flush) begin
                m_vld <= 1'b0; m_tkn <= 1'b0; m_ill <= 1'b0;
            end else if (!stall) begin
                m_vld <= in_valid;
                m_tkn <= in_valid && cond_ref(op, a, b);
                m_ill <= in_valid && (op == 3'd7);
            end
            ev = !flush && !stall && in_valid && (op >= 3'd1) && (op <= 3'd6);
            if (cnt_clr) begin
                m_cb <= 0; m_ct <= 0; m_cb2 <= 0; m_ct2 <= 0;
            end else if (ev) begin
                m_cb  <= sat(m_cb + 1, 16);
                m_cb2 <= sat(m_cb2 + 1, 2);
                if (cond_ref(op, a, b)) begin
                    m_ct  <= sat(m_ct + 1, 16);
                    m_ct2 <= sat(m_ct2 + 1, 2);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        chk("taken", 64'(taken), 64'(m_tkn));
        chk("illegal", 64'(illegal), 64'(m_ill));
        chk("cnt_branch", 64'(cnt_branch), 64'(m_cb));
        chk("cnt_taken", 64'(cnt_taken), 64'(m_ct));
        chk("out_valid2", 64'(out_valid2), 64'(m_vld));
        chk("taken2", 64'(taken2), 64'(m_tkn));
        chk("cnt_branch2", 64'(cnt_branch2), 64'(m_cb2));
        chk("cnt_taken2", 64'(cnt_taken2), 64'(m_ct2));
        chk("taken_le_branch", 64'(cnt_taken <= cnt_branch), 64'd1);
    end

    task automatic step(input logic iv, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic st, input logic fl, input logic clr);
        in_valid = iv; op = o; a = aa; b = bb; stall = st; flush = fl; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] av [3];
        logic [3:0]  tbl [3];
        logic [15:0] sv_cb, sv_ct;
        av[0] = 32'h0000_0000; tbl[0] = 4'b1001;  // {LEZ,GTZ,LTZ,GEZ}
        av[1] = 32'h8000_0000; tbl[1] = 4'b1010;
        av[2] = 32'h7FFF_FFFF; tbl[2] = 4'b0101;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cnt_branch", 64'(cnt_branch), 64'd0);
        reset = 1'b0;
        step(0, 3'd0, 0, 0, 0, 0, 0);

        // EQ then NE on equal operands
        step(1, 3'd1, 32'h1234, 32'h1234, 0, 0, 0);
        chk("eq_taken", 64'(taken), 64'd1);
        step(1, 3'd2, 32'h1234, 32'h1234, 0, 0, 0);
        chk("ne_taken", 64'(taken), 64'd0);
        chk("eqne_cnt_branch", 64'(cnt_branch), 64'd2);
        chk("eqne_cnt_taken", 64'(cnt_taken), 64'd1);

        // Sign boundaries
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                step(1, 3'(3 + j), av[i], 32'h0, 0, 0, 0);
                chk($sformatf("sign_a%0d_op%0d", i, 3 + j), 64'(taken), 64'(tbl[i][3-j]));
            end
        end

        // Stall holds a taken EQ, then flush overrides stall
        step(1, 3'd1, 32'd5, 32'd5, 0, 0, 0);
        sv_cb = cnt_branch; sv_ct = cnt_taken;
        for (int k = 0; k < 3; k++) begin
            step(k[0], 3'(k + 2), 32'(k), 32'h0, 1, 0, 0);
            chk("stall_taken", 64'(taken), 64'd1);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_cnt_branch", 64'(cnt_branch), 64'(sv_cb));
            chk("stall_cnt_taken", 64'(cnt_taken), 64'(sv_ct));
        end
        step(1, 3'd1, 32'd7, 32'd7, 1, 1, 0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_taken", 64'(taken), 64'd0);
        chk("flush_cnt_branch", 64'(cnt_branch), 64'(sv_cb));

        // Reserved and NONE ops
        step(1, 3'd7, 32'd1, 32'd1, 0, 0, 0);
        chk("rsvd_illegal", 64'(illegal), 64'd1);
        chk("rsvd_taken", 64'(taken), 64'd0);
        chk("rsvd_cnt_branch", 64'(cnt_branch), 64'(sv_cb));
        step(1, 3'd0, 32'd1, 32'd1, 0, 0, 0);
        chk("none_illegal", 64'(illegal), 64'd0);
        chk("none_valid", 64'(out_valid), 64'd1);
        chk("none_cnt_branch", 64'(cnt_branch), 64'(sv_cb));
        step(0, 3'd7, 32'd1, 32'd1, 0, 0, 0);
        chk("idle_illegal", 64'(illegal), 64'd0);

        // Saturation of the 2-bit counters, then clear wins over increment
        step(0, 3'd0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(1, 3'd1, 32'd9, 32'd9, 0, 0, 0);
        chk("sat_cnt_branch2", 64'(cnt_branch2), 64'd3);
        chk("sat_cnt_taken2", 64'(cnt_taken2), 64'd3);
        chk("nosat_cnt_branch", 64'(cnt_branch), 64'd5);
        step(1, 3'd1, 32'd9, 32'd9, 0, 0, 1);
        chk("clr_cnt_branch", 64'(cnt_branch), 64'd0);
        chk("clr_cnt_taken2", 64'(cnt_taken2), 64'd0);
        chk("clr_taken", 64'(taken), 64'd1);

        // Asynchronous reset mid-cycle with counters at 5/3
        step(0, 3'd0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 3'd1, 32'd4, 32'd4, 0, 0, 0);
        for (int k = 0; k < 2; k++) step(1, 3'd2, 32'd4, 32'd4, 0, 0, 0);
        chk("pre_rst_cnt_branch", 64'(cnt_branch), 64'd5);
        chk("pre_rst_cnt_taken", 64'(cnt_taken), 64'd3);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_cnt_branch", 64'(cnt_branch), 64'd0);
        chk("async_rst_cnt_taken", 64'(cnt_taken), 64'd0);
        in_valid = 1'b0; op = 3'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 3'd0, 0, 0, 0, 0, 0);
        chk("post_rst_cnt_branch", 64'(cnt_branch), 64'd0);
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        step(0, 3'd0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
